ysyx_220066_dmem_wr: RTL

- Store buffer for the MEM stage, the write-side counterpart of the data-memory load path.
- Accepts stores from EX/MEM through a valid/ready handshake and converts each one into an 8-byte-aligned address, a lane-shifted 64-bit data word and a byte mask.
- Queues entries in a DEPTH-entry FIFO and drains them one at a time to the memory write port under a small FSM.
- Reports a hazard to the load path when a pending store overlaps a load address.

---
 rtl/ysyx_220066_dmem_wr.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_220066_dmem_wr.sv
// MEM-stage store buffer: lane-aligns stores, queues them and drains them to the memory write port.
// Optional build macro STBUF_MERGE_EN coalesces a push into a matching, not-yet-latched tail entry.

module ysyx_220066_dmem_wr_ent #(
  parameter int AW = 64
) (
  input  logic          vld,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    mask,
  input  logic [AW-1:0] ld_line,
  input  logic [7:0]    ld_mask,
  output logic          hit
);
  assign hit = vld && (addr == ld_line) && (|(mask & ld_mask));
endmodule

module ysyx_220066_dmem_wr #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [63:0]            in_data,
  input  logic [1:0]             in_memop,
  output logic                   in_err,
  output logic                   mem_wvalid,
  input  logic                   mem_wready,
  output logic [AW-1:0]          mem_waddr,
  output logic [63:0]            mem_wdata,
  output logic [7:0]             mem_wmask,
  input  logic [AW-1:0]          ld_addr,
  input  logic [1:0]             ld_size,
  output logic                   ld_hit,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [7:0]    mask;
  } ent_t;

  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [3:0]  nb;
    logic [15:0] m;
    nb = 4'd1 << size;
    m  = ((16'd1 << nb) - 16'd1) << off;
    return m[7:0];
  endfunction

  ent_t [DEPTH-1:0] fifo_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic [0:0]       state;

  logic          misal, push, alloc, mrg, pop, can_merge;
  logic [PW-1:0] tail_idx, next_idx;
  ent_t          push_ent;

  always_comb begin
    misal = 1'b0;
    case (in_memop)
      2'b00:   misal = 1'b0;
      2'b01:   misal = in_addr[0];
      2'b10:   misal = |in_addr[1:0];
      default: misal = |in_addr[2:0];
    endcase
  end

  assign push_ent.addr = {in_addr[AW-1:3], 3'b000};
  assign push_ent.data = in_data << {in_addr[2:0], 3'b000};
  assign push_ent.mask = byte_mask(in_memop, in_addr[2:0]);

  assign tail_idx = wr_ptr - 1'b1;
  assign next_idx = rd_ptr + 1'b1;
  assign pop      = (state == S_SEND) && mem_wready;

`ifdef STBUF_MERGE_EN
  // The tail must not be the entry already in (or about to enter) the mem_* registers.
  assign can_merge = !misal && (cnt != '0) && (fifo_q[tail_idx].addr == push_ent.addr) &&
                     (tail_idx != rd_ptr) && !(pop && (tail_idx == next_idx));
`else
  assign can_merge = 1'b0;
`endif

  assign in_ready = (cnt < CW'(DEPTH)) || can_merge;
  assign push     = in_valid && in_ready;
  assign alloc    = push && !misal && !can_merge;
  assign mrg      = push && can_merge;

  always_ff @(posedge clk) begin
    if (alloc) fifo_q[wr_ptr] <= push_ent;
    if (mrg) begin
      fifo_q[tail_idx].mask <= fifo_q[tail_idx].mask | push_ent.mask;
      for (int b = 0; b < 8; b++)
        if (push_ent.mask[b]) fifo_q[tail_idx].data[8*b +: 8] <= push_ent.data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      state     <= S_IDLE;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      in_err    <= 1'b0;
    end else begin
      in_err <= push && misal;
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= next_idx;
      if (alloc && !pop)      cnt <= cnt + 1'b1;
      else if (!alloc && pop) cnt <= cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (cnt != '0) begin
            mem_waddr <= fifo_q[rd_ptr].addr;
            mem_wdata <= fifo_q[rd_ptr].data;
            mem_wmask <= fifo_q[rd_ptr].mask;
            state     <= S_SEND;
          end
        end
        default: begin
          // Back-to-back: the next entry was written at least one edge ago, so it is readable now.
          if (mem_wready) begin
            if (cnt > CW'(1)) begin
              mem_waddr <= fifo_q[next_idx].addr;
              mem_wdata <= fifo_q[next_idx].data;
              mem_wmask <= fifo_q[next_idx].mask;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign mem_wvalid = (state == S_SEND);
  assign empty      = (cnt == '0) && (state == S_IDLE);
  assign count      = cnt;

  logic [AW-1:0]    ld_line;
  logic [7:0]       ld_mask;
  logic [DEPTH-1:0] ent_vld, ent_hit;

  assign ld_line = {ld_addr[AW-1:3], 3'b000};
  assign ld_mask = byte_mask(ld_size, ld_addr[2:0]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] rel;
    assign rel        = PW'(i) - rd_ptr;
    assign ent_vld[i] = CW'(rel) < cnt;
    ysyx_220066_dmem_wr_ent #(.AW(AW)) u_ent (
      .vld     (ent_vld[i]),
      .addr    (fifo_q[i].addr),
      .mask    (fifo_q[i].mask),
      .ld_line (ld_line),
      .ld_mask (ld_mask),
      .hit     (ent_hit[i])
    );
  end

  assign ld_hit = |ent_hit;
endmodule
